// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one memory (MMU) request/response channel between an
// instruction requester and a data requester.
//
// Ports
//   clk_in, rst_in                 clock, synchronous active-high reset
//   instruction_request_*          instruction fetch requests (always READ)
//   instruction_response_*         instruction read data back to the fetcher
//   data_request_*                 data requests (READ or WRITE, with write data)
//   data_response_*                data responses (one per request, READ or WRITE)
//   mmu_request_*                  arbitrated request toward memory
//   mmu_response_*                 in-order responses from memory
//   outstanding_count_out          accepted requests still awaiting a response
//
// Requests are arbitrated round-robin. Once a request is presented to memory
// it stays granted until memory accepts it. Every accepted request pushes a
// source tag (0 = instruction, 1 = data) into an in-order FIFO; the tag at the
// head steers the next memory response back to its issuer.

package processor_help;
    typedef logic [31:0] Word;
    typedef enum logic { READ = 1'b0, WRITE = 1'b1 } MemoryOperation;
endpackage

module memory_arbiter
    import processor_help::*;
#(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                               clk_in,
    input  logic                               rst_in,

    output logic                               instruction_request_ready_out,
    input  logic                               instruction_request_valid_in,
    input  Word                                instruction_request_address_in,

    input  logic                               instruction_response_ready_in,
    output logic                               instruction_response_valid_out,
    output Word                                instruction_response_data_out,

    output logic                               data_request_ready_out,
    input  logic                               data_request_valid_in,
    input  Word                                data_request_address_in,
    input  MemoryOperation                     data_request_operation_in,
    input  Word                                data_request_data_in,

    input  logic                               data_response_ready_in,
    output logic                               data_response_valid_out,
    output Word                                data_response_data_out,

    input  logic                               mmu_request_ready_in,
    output logic                               mmu_request_valid_out,
    output Word                                mmu_request_address_out,
    output MemoryOperation                     mmu_request_operation_out,
    output Word                                mmu_request_data_out,

    output logic                               mmu_response_ready_out,
    input  logic                               mmu_response_valid_in,
    input  Word                                mmu_response_data_in,

    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_count_out
);
    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    // Tag FIFO; pointers wrap naturally because depth is a power of two.
    logic [MAX_OUTSTANDING-1:0] tag_q;
    logic [PW-1:0]              wr_ptr_q;
    logic [PW-1:0]              rd_ptr_q;
    logic [CW-1:0]              count_q;

    logic lock_q;          // request presented but not yet taken by memory
    logic lock_src_q;      // which requester the held grant belongs to
    logic prefer_data_q;   // round-robin winner when both requesters are valid

    logic grant_data;
    logic grant_valid;
    logic not_full;
    logic fifo_empty;
    logic head_tag;
    logic req_fire;
    logic rsp_fire;

    always_comb begin
        // Full is judged on the registered count only, so a pop in the same
        // cycle never lets a new request slip in at the limit.
        not_full   = count_q < MAX_CNT;
        fifo_empty = count_q == '0;
        head_tag   = tag_q[rd_ptr_q];

        if (lock_q)
            grant_data = lock_src_q;
        else if (instruction_request_valid_in && data_request_valid_in)
            grant_data = prefer_data_q;
        else
            grant_data = data_request_valid_in;

        grant_valid = grant_data ? data_request_valid_in : instruction_request_valid_in;

        mmu_request_valid_out     = !rst_in && grant_valid && not_full;
        mmu_request_address_out   = grant_data ? data_request_address_in : instruction_request_address_in;
        mmu_request_operation_out = grant_data ? data_request_operation_in : READ;
        mmu_request_data_out      = grant_data ? data_request_data_in : '0;

        instruction_request_ready_out = !rst_in && !grant_data && mmu_request_ready_in && not_full;
        data_request_ready_out        = !rst_in &&  grant_data && mmu_request_ready_in && not_full;

        // Responses only look at the registered FIFO state, so a request
        // accepted this cycle can never be answered in the same cycle.
        mmu_response_ready_out = !rst_in && !fifo_empty &&
                                 (head_tag ? data_response_ready_in : instruction_response_ready_in);
        instruction_response_valid_out = !rst_in && !fifo_empty && !head_tag && mmu_response_valid_in;
        data_response_valid_out        = !rst_in && !fifo_empty &&  head_tag && mmu_response_valid_in;

        instruction_response_data_out = mmu_response_data_in;
        data_response_data_out        = mmu_response_data_in;

        req_fire = mmu_request_valid_out && mmu_request_ready_in;
        rsp_fire = mmu_response_ready_out && mmu_response_valid_in;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            lock_q        <= 1'b0;
            lock_src_q    <= 1'b0;
            prefer_data_q <= 1'b0;
        end else begin
            if (req_fire) begin
                tag_q[wr_ptr_q] <= grant_data;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
                prefer_data_q   <= !grant_data;
            end
            if (rsp_fire)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(req_fire) - CW'(rsp_fire);
            // While locked grant_data already equals lock_src_q, so tracking
            // the current grant every cycle keeps the held source stable.
            lock_q     <= mmu_request_valid_out && !mmu_request_ready_in;
            lock_src_q <= grant_data;
        end
    end

    assign outstanding_count_out = count_q;

endmodule
